// File: rtl/matrix_loader_if.sv
// matrix_loader_if
// Bundles the descriptor handshake, the element byte stream and the
// registered operand bus that feeds the matrix ALU.
//   master : upstream source of descriptors/bytes, and consumer of operands
//   slave  : the matrix_loader itself
interface matrix_loader_if #(
  parameter int DIM_MAX = 5,
  parameter int ELEM_W  = 8
);
  localparam int MAT_W = DIM_MAX * DIM_MAX * ELEM_W;

  // descriptor channel
  logic              cfg_valid;
  logic              cfg_ready;
  logic [2:0]        op_code_in;
  logic [ELEM_W-1:0] scalar_in;
  logic [2:0]        size_in;

  // element byte stream
  logic              data_valid;
  logic              data_ready;
  logic [ELEM_W-1:0] data_in;

  // operand bus towards the ALU
  logic [2:0]        op_code;
  logic [ELEM_W-1:0] scalar;
  logic [MAT_W-1:0]  matrix_a;
  logic [MAT_W-1:0]  matrix_b;
  logic              start;
  logic              err;

  modport master (
    output cfg_valid, op_code_in, scalar_in, size_in,
    output data_valid, data_in,
    input  cfg_ready, data_ready,
    input  op_code, scalar, matrix_a, matrix_b, start, err
  );

  modport slave (
    input  cfg_valid, op_code_in, scalar_in, size_in,
    input  data_valid, data_in,
    output cfg_ready, data_ready,
    output op_code, scalar, matrix_a, matrix_b, start, err
  );
endinterface

// File: rtl/matrix_loader.sv
// matrix_loader
// Operand front-end for the matrix ALU. Takes one operation descriptor, then
// a row-major stream of signed bytes, and assembles matrix A (and B for
// binary ops) into the ALU's zero-padded DIM_MAX x DIM_MAX packed layout.
// A one-cycle start pulse is issued once all operands are in place; the
// operands then stay stable until the next descriptor is accepted.
//
// Optional feature: define MATRIX_LOADER_CHECKSUM_EN to require one trailing
// XOR checksum byte after each operand (states CHK_A/CHK_B). A mismatching
// checksum aborts the operation with err set and no start.
module matrix_loader #(
  parameter int DIM_MAX = 5,
  parameter int ELEM_W  = 8
) (
  input logic           clk,
  input logic           rst,
  matrix_loader_if.slave bus
);

  localparam int         MAT_W     = DIM_MAX * DIM_MAX * ELEM_W;
  localparam int         IDX_W     = $clog2(MAT_W);
  localparam logic [2:0] DIM_MAX_L = 3'(DIM_MAX);
  localparam logic [2:0] DIM_MIN_L = 3'd2;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ISSUE  = 3'd3
`ifdef MATRIX_LOADER_CHECKSUM_EN
    ,
    CHK_A  = 3'd4,
    CHK_B  = 3'd5
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         row_q, row_d;
  logic [2:0]         col_q, col_d;
  logic [2:0]         n_q, n_d;
  logic [2:0]         op_q, op_d;
  logic [ELEM_W-1:0]  scalar_q, scalar_d;
  logic [MAT_W-1:0]   mat_a_q, mat_a_d;
  logic [MAT_W-1:0]   mat_b_q, mat_b_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               data_ready_q, data_ready_d;
  logic               start_q, start_d;
  logic               err_q, err_d;
`ifdef MATRIX_LOADER_CHECKSUM_EN
  logic [ELEM_W-1:0]  xor_q, xor_d;
`endif

  logic               desc_legal;
  logic               is_binary;
  logic               accept_byte;
  logic               last_elem;
  logic               last_col;
  logic [IDX_W-1:0]   elem_base;

  // Descriptor legality, operand count, and stream position decode.
  always_comb begin
    desc_legal  = (bus.op_code_in != OP_ILLEGAL) &&
                  (bus.size_in >= DIM_MIN_L) &&
                  (bus.size_in <= DIM_MAX_L);
    is_binary   = (op_q == 3'b000) || (op_q == 3'b001) || (op_q == 3'b110);
    accept_byte = bus.data_valid && data_ready_q;
    last_col    = (col_q == (n_q - 3'd1));
    last_elem   = last_col && (row_q == (n_q - 3'd1));
    elem_base   = IDX_W'((int'(row_q) * DIM_MAX + int'(col_q)) * ELEM_W);
  end

  // Next-state and next-output logic; every register holds unless told otherwise.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    n_d       = n_q;
    op_d      = op_q;
    scalar_d  = scalar_q;
    mat_a_d   = mat_a_q;
    mat_b_d   = mat_b_q;
    err_d     = err_q;
`ifdef MATRIX_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          if (desc_legal) begin
            op_d     = bus.op_code_in;
            scalar_d = bus.scalar_in;
            n_d      = bus.size_in;
            mat_a_d  = '0;
            mat_b_d  = '0;
            err_d    = 1'b0;
            row_d    = 3'd0;
            col_d    = 3'd0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            xor_d    = '0;
`endif
            state_d  = LOAD_A;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD_A, LOAD_B: begin
        if (accept_byte) begin
          if (state_q == LOAD_A) begin
            mat_a_d[elem_base +: ELEM_W] = bus.data_in;
          end else begin
            mat_b_d[elem_base +: ELEM_W] = bus.data_in;
          end
`ifdef MATRIX_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ bus.data_in;
`endif
          if (last_elem) begin
            row_d = 3'd0;
            col_d = 3'd0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            state_d = (state_q == LOAD_A) ? CHK_A : CHK_B;
`else
            state_d = ((state_q == LOAD_A) && is_binary) ? LOAD_B : ISSUE;
`endif
          end else if (last_col) begin
            col_d = 3'd0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end

`ifdef MATRIX_LOADER_CHECKSUM_EN
      CHK_A, CHK_B: begin
        if (accept_byte) begin
          xor_d = '0;
          if (bus.data_in == xor_q) begin
            state_d = ((state_q == CHK_A) && is_binary) ? LOAD_B : ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif

      ISSUE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    cfg_ready_d  = (state_d == IDLE);
    start_d      = (state_d == ISSUE);
    data_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B)
`ifdef MATRIX_LOADER_CHECKSUM_EN
                   || (state_d == CHK_A) || (state_d == CHK_B)
`endif
                   ;
  end

  // State and output registers; reset wins over any in-flight load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      row_q        <= 3'd0;
      col_q        <= 3'd0;
      n_q          <= 3'd0;
      op_q         <= 3'd0;
      scalar_q     <= '0;
      mat_a_q      <= '0;
      mat_b_q      <= '0;
      cfg_ready_q  <= 1'b1;
      data_ready_q <= 1'b0;
      start_q      <= 1'b0;
      err_q        <= 1'b0;
`ifdef MATRIX_LOADER_CHECKSUM_EN
      xor_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      n_q          <= n_d;
      op_q         <= op_d;
      scalar_q     <= scalar_d;
      mat_a_q      <= mat_a_d;
      mat_b_q      <= mat_b_d;
      cfg_ready_q  <= cfg_ready_d;
      data_ready_q <= data_ready_d;
      start_q      <= start_d;
      err_q        <= err_d;
`ifdef MATRIX_LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign bus.cfg_ready  = cfg_ready_q;
  assign bus.data_ready = data_ready_q;
  assign bus.op_code    = op_q;
  assign bus.scalar     = scalar_q;
  assign bus.matrix_a   = mat_a_q;
  assign bus.matrix_b   = mat_b_q;
  assign bus.start      = start_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_matrix_loader.sv
// tb_matrix_loader
// Randomized bench for matrix_loader. A transaction-level model counts
// accepted bytes and places each one by its position in the stream; a
// negedge compare process checks every output every cycle against it.
// Directed scenarios add hand-computed literal checks on top.
module tb_matrix_loader;

  logic clk;
  logic rst;

  matrix_loader_if #(.DIM_MAX(5), .ELEM_W(8)) bus ();

  matrix_loader #(.DIM_MAX(5), .ELEM_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MATRIX_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  int total     = 0;
  int bad       = 0;
  int cyc       = 0;
  int descCyc   = 0;
  int acceptCnt = 0;
  int startQ[$];

  // model state: phase 0 idle, 1 receiving stream, 2 issuing
  int         mPhase = 0;
  int         mN, mCount, mTotal, mPer, mOpnd, mK;
  logic [2:0] mOp;
  logic [7:0] mScalar;
  logic       mErr;
  logic [7:0] mA [25];
  logic [7:0] mB [25];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit isBin(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd6);
  endfunction

  function automatic logic [199:0] packMat(input logic [7:0] m [25]);
    logic [199:0] v;
    v = '0;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = m[i];
    return v;
  endfunction

  function automatic logic [7:0] xorOf(input logic [7:0] m [25], input int n);
    logic [7:0] x;
    x = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) x ^= m[r*5 + c];
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [199:0] act, input logic [199:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // reference model, advanced on each rising edge from the driven inputs
  always @(posedge clk) begin
    cyc++;
    if (bus.data_valid && bus.data_ready) acceptCnt++;
    if (!rst) begin
      mPhase  = 0;
      mOp     = '0;
      mScalar = '0;
      mErr    = 1'b0;
      for (int i = 0; i < 25; i++) begin mA[i] = '0; mB[i] = '0; end
    end else if (mPhase == 0) begin
      if (bus.cfg_valid) begin
        if (bus.op_code_in != 3'd7 && bus.size_in >= 3'd2 && bus.size_in <= 3'd5) begin
          mOp     = bus.op_code_in;
          mScalar = bus.scalar_in;
          mN      = int'(bus.size_in);
          mErr    = 1'b0;
          mCount  = 0;
          mPer    = mN * mN + CK;
          mTotal  = mPer * (isBin(mOp) ? 2 : 1);
          for (int i = 0; i < 25; i++) begin mA[i] = '0; mB[i] = '0; end
          mPhase  = 1;
        end else begin
          mErr = 1'b1;
        end
      end
    end else if (mPhase == 1) begin
      if (bus.data_valid) begin
        mOpnd = mCount / mPer;
        mK    = mCount % mPer;
        if (mK < mN * mN) begin
          if (mOpnd == 0) mA[(mK / mN) * 5 + (mK % mN)] = bus.data_in;
          else            mB[(mK / mN) * 5 + (mK % mN)] = bus.data_in;
        end else if (bus.data_in != ((mOpnd == 0) ? xorOf(mA, mN) : xorOf(mB, mN))) begin
          mErr   = 1'b1;
          mPhase = 0;
        end
        mCount++;
        if (mPhase == 1 && mCount == mTotal) mPhase = 2;
      end
    end else begin
      mPhase = 0;
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cyc > 0) begin
      checkOutput("cfg_ready",  bus.cfg_ready,  mPhase == 0);
      checkOutput("data_ready", bus.data_ready, mPhase == 1);
      checkOutput("start",      bus.start,      mPhase == 2);
      checkOutput("err",        bus.err,        mErr);
      checkOutput("op_code",    bus.op_code,    mOp);
      checkOutput("scalar",     bus.scalar,     mScalar);
      checkOutput("matrix_a",   bus.matrix_a,   packMat(mA));
      checkOutput("matrix_b",   bus.matrix_b,   packMat(mB));
      if (bus.start) startQ.push_back(cyc);
    end
  end

  task automatic junkCfg();
    bus.cfg_valid  = ($urandom_range(0, 3) == 0);
    bus.op_code_in = 3'($urandom_range(0, 7));
    bus.scalar_in  = 8'($urandom);
    bus.size_in    = 3'($urandom_range(0, 7));
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.cfg_valid  = 1'b0;
      bus.data_valid = 1'($urandom_range(0, 1));
      bus.data_in    = 8'($urandom);
    end
  endtask

  task automatic sendDesc(input logic [2:0] op, input logic [7:0] scal, input logic [2:0] size);
    @(negedge clk);
    bus.cfg_valid  = 1'b1;
    bus.op_code_in = op;
    bus.scalar_in  = scal;
    bus.size_in    = size;
    bus.data_valid = 1'($urandom_range(0, 1));
    bus.data_in    = 8'($urandom);
    descCyc        = cyc;
  endtask

  // stallMode: 0 none, 1 one idle cycle before each byte, 2 random 0..2
  task automatic sendByte(input logic [7:0] b, input int stallMode);
    int stalls;
    int guard;
    stalls = (stallMode == 1) ? 1 : (stallMode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (stalls) begin
      @(negedge clk);
      bus.data_valid = 1'b0;
      bus.data_in    = 8'($urandom);
      junkCfg();
    end
    guard = 0;
    forever begin
      @(negedge clk);
      bus.data_valid = 1'b1;
      bus.data_in    = b;
      junkCfg();
      if (bus.data_ready === 1'b1) break;
      guard++;
      if (guard > 50) begin
        total++;
        bad++;
        $display("[TB] FAIL byte_wait: data_ready=%b, required 1 within 50 cycles", bus.data_ready);
        break;
      end
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] scal, input logic [2:0] size,
                               input logic [7:0] bytes[$], input int stallMode,
                               input logic [7:0] chkFlip, input bit noTail);
    int n;
    logic [7:0] run;
    sendDesc(op, scal, size);
    n = int'(size);
    if (op != 3'd7 && n >= 2 && n <= 5) begin
      run = '0;
      for (int i = 0; i < bytes.size(); i++) begin
        sendByte(bytes[i], stallMode);
        run ^= bytes[i];
        if (CK == 1 && ((i + 1) % (n * n)) == 0) begin
          sendByte(run ^ chkFlip, stallMode);
          run = '0;
        end
      end
    end
    if (!noTail) idleCycles(2);
  endtask

  initial begin
    logic [7:0]   q[$];
    logic [199:0] allTwos;
    int           acceptBase;

    rst = 1'b0;
    bus.cfg_valid  = 1'b0;
    bus.op_code_in = '0;
    bus.scalar_in  = '0;
    bus.size_in    = '0;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    checkOutput("rst_cfg_ready", bus.cfg_ready, 1'b1);
    checkOutput("rst_matrix_a",  bus.matrix_a,  '0);

    // binary add, N=5, no stalls
    $display("[TB] binary add N=5");
    q.delete();
    for (int i = 1; i <= 25; i++) q.push_back(8'(i));
    for (int i = 0; i < 25; i++) q.push_back(8'd2);
    startQ.delete();
    applyStimulus(3'd0, 8'd0, 3'd5, q, 0, 8'h00, 1'b0);
    allTwos = '0;
    for (int i = 0; i < 25; i++) allTwos[i*8 +: 8] = 8'h02;
    checkOutput("bin_a_first", bus.matrix_a[7:0], 8'd1);
    checkOutput("bin_a_last",  bus.matrix_a[199:192], 8'd25);
    checkOutput("bin_b_all2",  bus.matrix_b, allTwos);
    checkOutput("bin_start_count", startQ.size(), 1);
    if (startQ.size() > 0) checkOutput("bin_start_cycle", startQ[0] - descCyc, 51 + 2 * CK);

    // unary N=3 with extra bytes offered after the last element
    $display("[TB] unary N=3");
    q.delete();
    for (int i = 1; i <= 9; i++) q.push_back(8'(i));
    startQ.delete();
    acceptBase = acceptCnt;
    applyStimulus(3'd2, 8'd0, 3'd3, q, 0, 8'h00, 1'b1);
    @(negedge clk);
    bus.cfg_valid = 1'b0; bus.data_valid = 1'b1; bus.data_in = 8'h77;
    checkOutput("un_start_next", bus.start, 1'b1);
    repeat (2) begin @(negedge clk); bus.cfg_valid = 1'b0; bus.data_valid = 1'b1; end
    checkOutput("un_accept_cnt", acceptCnt - acceptBase, 9 + CK);
    checkOutput("un_data_ready", bus.data_ready, 1'b0);
    checkOutput("un_a_10", bus.matrix_a[47:40], 8'd4);
    checkOutput("un_a_pad", bus.matrix_a[39:24], 16'd0);
    checkOutput("un_b_zero", bus.matrix_b, '0);

    // scalar op with alternating stalls
    $display("[TB] stalls N=2");
    q = '{8'hFF, 8'h02, 8'hFD, 8'h04};
    startQ.delete();
    applyStimulus(3'd4, 8'hFD, 3'd2, q, 1, 8'h00, 1'b0);
    checkOutput("st_a00", bus.matrix_a[7:0],   8'hFF);
    checkOutput("st_a01", bus.matrix_a[15:8],  8'h02);
    checkOutput("st_a10", bus.matrix_a[47:40], 8'hFD);
    checkOutput("st_a11", bus.matrix_a[55:48], 8'h04);
    checkOutput("st_scalar", bus.scalar, 8'hFD);
    checkOutput("st_start_count", startQ.size(), 1);

    // illegal descriptors
    $display("[TB] illegal descriptors");
    q.delete();
    startQ.delete();
    applyStimulus(3'd7, 8'd0, 3'd3, q, 0, 8'h00, 1'b0);
    checkOutput("ill_op_err", bus.err, 1'b1);
    checkOutput("ill_op_cfg_ready", bus.cfg_ready, 1'b1);
    checkOutput("ill_op_data_ready", bus.data_ready, 1'b0);
    applyStimulus(3'd0, 8'd0, 3'd6, q, 0, 8'h00, 1'b0);
    checkOutput("ill_size_err", bus.err, 1'b1);
    checkOutput("ill_size_data_ready", bus.data_ready, 1'b0);
    checkOutput("ill_start_count", startQ.size(), 0);

    // reset during LOAD_B, then a fresh small load
    $display("[TB] reset mid-load");
    q.delete();
    for (int i = 0; i < 35; i++) q.push_back(8'($urandom));
    applyStimulus(3'd0, 8'h5A, 3'd5, q, 0, 8'h00, 1'b1);
    @(negedge clk);
    bus.cfg_valid = 1'b0; bus.data_valid = 1'b1; bus.data_in = 8'hAA;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("rm_cfg_ready", bus.cfg_ready, 1'b1);
    checkOutput("rm_data_ready", bus.data_ready, 1'b0);
    checkOutput("rm_op", bus.op_code, 3'd0);
    checkOutput("rm_scalar", bus.scalar, 8'd0);
    checkOutput("rm_a", bus.matrix_a, '0);
    checkOutput("rm_b", bus.matrix_b, '0);
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    startQ.delete();
    applyStimulus(3'd0, 8'd0, 3'd2, q, 2, 8'h00, 1'b0);
    checkOutput("rm2_a01", bus.matrix_a[15:8], 8'h22);
    checkOutput("rm2_b11", bus.matrix_b[55:48], 8'h88);
    checkOutput("rm2_start_count", startQ.size(), 1);

`ifdef MATRIX_LOADER_CHECKSUM_EN
    $display("[TB] checksum");
    q = '{8'd1, 8'd2, 8'd3, 8'd4};
    startQ.delete();
    applyStimulus(3'd3, 8'd0, 3'd2, q, 0, 8'h00, 1'b0);
    checkOutput("ck_good_start", startQ.size(), 1);
    checkOutput("ck_good_err", bus.err, 1'b0);
    startQ.delete();
    applyStimulus(3'd3, 8'd0, 3'd2, q, 0, 8'h01, 1'b0);
    checkOutput("ck_bad_start", startQ.size(), 0);
    checkOutput("ck_bad_err", bus.err, 1'b1);
`endif

    // randomized transactions
    $display("[TB] random transactions");
    for (int t = 0; t < 40; t++) begin
      logic [2:0] op;
      logic [2:0] size;
      logic [7:0] flip;
      int         cnt;
      op   = 3'($urandom_range(0, 7));
      size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 5));
      flip = (CK == 1 && $urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      cnt  = int'(size) * int'(size) * (isBin(op) ? 2 : 1);
      if (flip != 8'h00) cnt = int'(size) * int'(size);
      q.delete();
      for (int k = 0; k < cnt; k++) q.push_back(8'($urandom));
      applyStimulus(op, 8'($urandom), size, q, 2, flip, 1'b0);
      idleCycles(int'($urandom_range(0, 2)));
    end
    idleCycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Front-end operand loader that sits directly upstream of the matrix ALU. It accepts an operation descriptor and a byte stream of signed 8-bit matrix elements, then assembles matrix A and, for binary ops, matrix B into the ALU's 200-bit packed operand format. When operands are complete it issues a one-cycle `start` to the ALU. It supports square matrices of dimension 2..5, zero-padded into the fixed 5x5 layout.

## Interface
- `DIM_MAX`, 5: maximum matrix dimension; the packed layout is always DIM_MAX x DIM_MAX.
- `ELEM_W`, 8: element width in bits.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `cfg_valid`  in  1  descriptor present.
- `cfg_ready`  out  1  high only in IDLE.
- `op_code_in`  in  3  operation code, ALU encoding.
- `scalar_in`  in  8  signed scalar for op 100.
- `size_in`  in  3  matrix dimension N; legal values 2..5.
- `data_valid`  in  1  element byte present.
- `data_ready`  out  1  loader accepts a byte.
- `data_in`  in  8  signed element, row-major order.
- `op_code`  out  3  registered op to the ALU.
- `scalar`  out  8  registered scalar to the ALU.
- `matrix_a`  out  200  packed A; element (r,c) at bits [(r*5+c)*8 +: 8].
- `matrix_b`  out  200  packed B, same layout.
- `start`  out  1  one-cycle issue pulse to the ALU.
- `err`  out  1  sticky error flag.

## Operation
- **States:** IDLE, LOAD_A, LOAD_B, ISSUE; CHK_A and CHK_B exist only with the checksum feature.
- **IDLE:**
  - `cfg_ready`=1 and `data_ready`=0.
  - A descriptor is accepted on `cfg_valid`.
  - On acceptance, `op_code`, `scalar` and N are latched. `matrix_a` and `matrix_b` are cleared to 0 so that padding is zero. `err` is cleared.
- **Illegal descriptor:** `op_code_in`=111, or `size_in`<2, or `size_in`>5.
  - `err` is set and the FSM stays in IDLE.
  - No load and no `start` occur.
- **Operand count:**
  - Binary ops (000, 001, 110) load A, then B.
  - Unary ops (010, 011, 100, 101) load A only. `matrix_b` stays 0.
- **LOAD_A / LOAD_B:**
  - `data_ready`=1. A byte is accepted when `data_valid` and `data_ready` are both high.
  - Row and column counters r, c start at 0. The accepted byte is written to (r,c) of the active matrix.
  - c increments; when c wraps at N-1, c returns to 0 and r increments.
  - Positions with r≥N or c≥N are never written.
- **Transitions:**
  - After the N*N-th byte of A: go to LOAD_B for binary ops, or ISSUE for unary ops. Counters reset.
  - After the N*N-th byte of B: go to ISSUE.
- **ISSUE:** `start`=1 for exactly one cycle, then return to IDLE.
- **Output hold:** `op_code`, `scalar`, `matrix_a` and `matrix_b` hold their values until the next accepted descriptor, so the sequential ALU multiplier sees stable operands.
- **Stalls:** `data_valid` low in any cycle is a stall. No byte is lost or duplicated.
- **Ignored inputs:** `cfg_valid` is ignored outside IDLE. `data_valid` is ignored in IDLE and ISSUE.

## Timing
- **Reset:** `rst`=0 at a clock edge forces the following, taking priority over every other event, including mid-load:
  - State = IDLE.
  - `cfg_ready`=1.
  - `data_ready`, `start`, `err` = 0.
  - `op_code`, `scalar`, `matrix_a`, `matrix_b` = 0.
- **Outputs:** all outputs are registered.
- **Latency:**
  - `start` is high in the cycle immediately after the edge that accepts the final byte.
  - Binary N=5 with no stalls: descriptor at cycle 0, bytes in cycles 1..50, `start` in cycle 51.
  - `cfg_ready` returns high in the cycle after `start`.
- **Boundary transition:** in the cycle the last byte of A is accepted, `data_ready` stays high into LOAD_B with no bubble.
- **End of load:** after the last byte of the final operand, `data_ready` is low in ISSUE.

## Configuration
- **Macro:** `MATRIX_LOADER_CHECKSUM_EN`.
- **Defined:**
  - After the N*N-th byte of each operand, the FSM enters CHK_A or CHK_B and accepts one extra byte.
  - That byte must equal the XOR of the operand's N*N bytes.
  - On a match, flow continues as normal.
  - On a mismatch, `err`=1, the FSM returns to IDLE and no `start` is issued.
  - Binary N=5 latency becomes 53 cycles to `start`.
- **Undefined:** the CHK states and the XOR accumulator are absent. The stream carries elements only.

## Test plan
- **Binary add:** op 000, N=5; A bytes 1..25, B bytes all 2 → `start` is high in cycle 51 only. `matrix_a[7:0]`=1, `matrix_a[199:192]`=25, and every byte of `matrix_b` = 2.
- **Unary, N=3:** op 010, N=3, bytes 1..9 → exactly 9 bytes accepted and `data_ready` drops. Element (1,0)=4 at bits [47:40]. Bits [39:24]=0 and `matrix_b`=0. `start` occurs one cycle after the 9th byte.
- **Stalls:** op 100, scalar=-3, N=2, `data_valid` alternating 1/0 with bytes -1, 2, -3, 4 → `matrix_a` elements (0,0)=0xFF, (0,1)=0x02, (1,0)=0xFD, (1,1)=0x04. `scalar`=0xFD and a single `start`.
- **Illegal descriptors:** `op_code_in`=111, then `size_in`=6 → `err`=1 each time. No `start`, `data_ready` stays 0, `cfg_ready` stays 1.
- **Reset mid-load:** `rst`=0 during LOAD_B after 10 B bytes → next cycle all outputs are 0 and the FSM is in IDLE. A fresh op 000, N=2 load then completes correctly.
- **Checksum (`MATRIX_LOADER_CHECKSUM_EN` defined):** op 011, N=2, bytes 1, 2, 3, 4, checksum 0x04 → `start` issued. The same stream with checksum 0x05 → `err`=1 and no `start`.
